ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_stage_pkg.sv | 35 +++
 rtl/ex_stage_div.sv | 103 ++++++++++
 rtl/ex_stage.sv | 94 +++++++++
 tb/tb_ex_stage.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_stage_pkg.sv
// Shared constants for the execute stage: ALU selector and sub-op encodings,
// divider FSM state encoding and the divider step count.
// Ports: none (package).
package ex_stage_pkg;

  // Operation type (alusel) carried from decode through id/ex.
  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [2:0] EXE_RES_MOVE  = 3'b011;

  // Operation sub-type (aluop).
  localparam logic [7:0] EXE_OP_NOP  = 8'h00;
  localparam logic [7:0] EXE_OP_AND  = 8'h24;
  localparam logic [7:0] EXE_OP_OR   = 8'h25;
  localparam logic [7:0] EXE_OP_XOR  = 8'h26;
  localparam logic [7:0] EXE_OP_NOR  = 8'h27;
  localparam logic [7:0] EXE_OP_SLL  = 8'h7C;
  localparam logic [7:0] EXE_OP_SRL  = 8'h02;
  localparam logic [7:0] EXE_OP_SRA  = 8'h03;
  localparam logic [7:0] EXE_OP_MFHI = 8'h10;
  localparam logic [7:0] EXE_OP_MFLO = 8'h12;
  localparam logic [7:0] EXE_OP_DIV  = 8'h1A;
  localparam logic [7:0] EXE_OP_DIVU = 8'h1B;

  // One quotient bit is produced per RUN cycle.
  localparam int DivCycles = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_RUN  = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

endpackage

// File: rtl/ex_stage_div.sv
// Radix-2 restoring divider (signed/unsigned), 32 steps, abortable by annul.
// Ports: clk/rst; start_i, signed_i, annul_i, dividend_i, divisor_i in;
//        busy_o (stall request), done_o (result commit strobe), quotient_o, remainder_o out.
module div_unit
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic        annul_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o
);

  div_state_e  state_q;
  logic [4:0]  cnt_q;
  logic [31:0] dvd_q;   // dividend shifting out, quotient bits shifting in
  logic [31:0] dvs_q;
  logic [31:0] rem_q;
  logic        qneg_q;
  logic        rneg_q;

  logic [32:0] partial;
  logic        ge;
  logic [31:0] rem_nxt;
  logic [31:0] quo_nxt;
  logic        div_zero;
  logic        last_step;

  assign partial   = {rem_q, dvd_q[31]};
  assign ge        = partial >= {1'b0, dvs_q};
  assign rem_nxt   = ge ? 32'(partial - {1'b0, dvs_q}) : partial[31:0];
  assign quo_nxt   = {dvd_q[30:0], ge};
  assign div_zero  = (divisor_i == 32'd0);
  assign last_step = (cnt_q == 5'(DivCycles - 1));

  // Stall covers the accepting IDLE cycle and every RUN cycle; annul and
  // reset drop it immediately so the pipeline can flush.
  assign busy_o = ~rst & ~annul_i &
                  (((state_q == DIV_IDLE) & start_i) | (state_q == DIV_RUN));

  // Commit strobe: HI/LO are loaded on the same edge the FSM enters DONE,
  // so the new values are already visible while in DONE.
  assign done_o = ~annul_i &
                  (((state_q == DIV_IDLE) & start_i & div_zero) |
                   ((state_q == DIV_RUN) & last_step));

  always_comb begin
    quotient_o  = qneg_q ? -quo_nxt : quo_nxt;
    remainder_o = rneg_q ? -rem_nxt : rem_nxt;
    if (state_q == DIV_IDLE) begin
      quotient_o  = 32'hFFFF_FFFF;
      remainder_o = dividend_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else if (annul_i) begin
      state_q <= DIV_IDLE;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (start_i) begin
            if (div_zero) begin
              state_q <= DIV_DONE;
            end else begin
              dvd_q   <= (signed_i & dividend_i[31]) ? -dividend_i : dividend_i;
              dvs_q   <= (signed_i & divisor_i[31])  ? -divisor_i  : divisor_i;
              rem_q   <= '0;
              cnt_q   <= '0;
              qneg_q  <= signed_i & (dividend_i[31] ^ divisor_i[31]);
              rneg_q  <= signed_i & dividend_i[31];
              state_q <= DIV_RUN;
            end
          end
        end
        DIV_RUN: begin
          dvd_q <= quo_nxt;
          rem_q <= rem_nxt;
          cnt_q <= cnt_q + 5'd1;
          if (last_step) state_q <= DIV_DONE;
        end
        // The held divide retires here; never restart on it.
        DIV_DONE: state_q <= DIV_IDLE;
        default:  state_q <= DIV_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: logic/shift/move result mux, HI/LO registers, multi-cycle divide.
// Ports: clk/rst; alusel_i, aluop_i, reg1/reg2 operands, waddr_i, wreg_i, annul_i in;
//        wdata_o (combinational), waddr_o, wreg_o, hi_o, lo_o (registered), stall_req_o out.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  alusel_i,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] reg1_data_i,
  input  logic [31:0] reg2_data_i,
  input  logic [4:0]  waddr_i,
  input  logic        wreg_i,
  input  logic        annul_i,
  output logic [31:0] wdata_o,
  output logic [4:0]  waddr_o,
  output logic        wreg_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stall_req_o
);

  logic [31:0] hi_q, lo_q;
  logic        is_div;
  logic        div_done;
  logic [31:0] div_quo, div_rem;
  logic [4:0]  shamt;

  assign is_div = (aluop_i == EXE_OP_DIV) | (aluop_i == EXE_OP_DIVU);
  assign shamt  = reg1_data_i[4:0];

  div_unit u_div (
    .clk         (clk),
    .rst         (rst),
    .start_i     (is_div),
    .signed_i    (aluop_i == EXE_OP_DIV),
    .annul_i     (annul_i),
    .dividend_i  (reg1_data_i),
    .divisor_i   (reg2_data_i),
    .busy_o      (stall_req_o),
    .done_o      (div_done),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

  always_comb begin
    wdata_o = '0;
    case (alusel_i)
      EXE_RES_LOGIC: begin
        case (aluop_i)
          EXE_OP_AND: wdata_o = reg1_data_i & reg2_data_i;
          EXE_OP_OR:  wdata_o = reg1_data_i | reg2_data_i;
          EXE_OP_XOR: wdata_o = reg1_data_i ^ reg2_data_i;
          EXE_OP_NOR: wdata_o = ~(reg1_data_i | reg2_data_i);
          default:    wdata_o = '0;
        endcase
      end
      EXE_RES_SHIFT: begin
        case (aluop_i)
          EXE_OP_SLL: wdata_o = reg2_data_i << shamt;
          EXE_OP_SRL: wdata_o = reg2_data_i >> shamt;
          EXE_OP_SRA: wdata_o = $signed(reg2_data_i) >>> shamt;
          default:    wdata_o = '0;
        endcase
      end
      EXE_RES_MOVE: begin
        case (aluop_i)
          EXE_OP_MFHI: wdata_o = hi_q;
          EXE_OP_MFLO: wdata_o = lo_q;
          default:     wdata_o = '0;
        endcase
      end
      default: wdata_o = '0;
    endcase
  end

  // Divides write HI/LO, never the register file.
  assign waddr_o = waddr_i;
  assign wreg_o  = wreg_i & ~is_div;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (div_done) begin
      hi_q <= div_rem;
      lo_q <= div_quo;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  alusel_i;
  logic [7:0]  aluop_i;
  logic [31:0] reg1_data_i, reg2_data_i;
  logic [4:0]  waddr_i;
  logic        wreg_i;
  logic        annul_i;
  logic [31:0] wdata_o, hi_o, lo_o;
  logic [4:0]  waddr_o;
  logic        wreg_o, stall_req_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  ex_stage dut (
    .clk(clk), .rst(rst), .alusel_i(alusel_i), .aluop_i(aluop_i),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .waddr_i(waddr_i), .wreg_i(wreg_i), .annul_i(annul_i),
    .wdata_o(wdata_o), .waddr_o(waddr_o), .wreg_o(wreg_o),
    .hi_o(hi_o), .lo_o(lo_o), .stall_req_o(stall_req_o)
  );

  always #5 clk = ~clk;

  // Reference result for single-cycle ops, from the instruction semantics.
  function automatic logic [31:0] ref_result(input logic [2:0] sel, input logic [7:0] op,
                                              input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    int sh;
    r  = 32'd0;
    sh = int'(a[4:0]);
    if (sel == EXE_RES_LOGIC) begin
      if (op == EXE_OP_AND) r = a & b;
      else if (op == EXE_OP_OR) r = a | b;
      else if (op == EXE_OP_XOR) r = a ^ b;
      else if (op == EXE_OP_NOR) r = ~(a | b);
    end else if (sel == EXE_RES_SHIFT) begin
      if (op == EXE_OP_SLL) r = b << sh;
      else if (op == EXE_OP_SRL) r = b >> sh;
      else if (op == EXE_OP_SRA) begin
        r = b >> sh;
        if (b[31]) r = r | ~(32'hFFFF_FFFF >> sh);
      end
    end else if (sel == EXE_RES_MOVE) begin
      if (op == EXE_OP_MFHI) r = m_hi;
      else if (op == EXE_OP_MFLO) r = m_lo;
    end
    return r;
  endfunction

  task automatic drive(input logic [2:0] sel, input logic [7:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    alusel_i = sel; aluop_i = op; reg1_data_i = a; reg2_data_i = b;
  endtask

  task automatic check_alu(input string name, input logic [2:0] sel, input logic [7:0] op,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    @(negedge clk);
    drive(sel, op, a, b);
    waddr_i = 5'($urandom_range(0, 31));
    wreg_i  = 1'b1;
    #1;
    checks++;
    if (wdata_o !== exp) begin
      errors++;
      $display("FAIL %s wdata got %h want %h", name, wdata_o, exp);
    end
    checks++;
    if (waddr_o !== waddr_i || wreg_o !== 1'b1 || stall_req_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_ctrl waddr %0d/%0d wreg %b stall %b want wreg 1 stall 0",
               name, waddr_o, waddr_i, wreg_o, stall_req_o);
    end
  endtask

  task automatic check_hilo(input string name, input logic [31:0] eh, input logic [31:0] el);
    checks++;
    if (hi_o !== eh || lo_o !== el) begin
      errors++;
      $display("FAIL %s hi %h lo %h want hi %h lo %h", name, hi_o, lo_o, eh, el);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; annul_i = 1'b0; waddr_i = '0; wreg_i = 1'b0;
    drive(EXE_RES_NOP, EXE_OP_DIV, 32'd100, 32'd7);
    #1;
    checks++;
    if (stall_req_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall got %b want 0", stall_req_o);
    end
    check_hilo("reset_hilo", 32'd0, 32'd0);
    drive(EXE_RES_NOP, EXE_OP_NOP, 32'd0, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (wdata_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_nop wdata got %h want 0", wdata_o);
    end
  endtask

  task automatic test_logic();
    logic [7:0] ops[4] = '{EXE_OP_AND, EXE_OP_OR, EXE_OP_XOR, EXE_OP_NOR};
    logic [31:0] a, b;
    check_alu("and_fixed", EXE_RES_LOGIC, EXE_OP_AND, 32'hF0F0_00FF, 32'h0FF0_FF0F, 32'h00F0_000F);
    check_alu("or_fixed",  EXE_RES_LOGIC, EXE_OP_OR,  32'hF0F0_00FF, 32'h0FF0_FF0F, 32'hFFF0_FFFF);
    check_alu("nor_fixed", EXE_RES_LOGIC, EXE_OP_NOR, 32'hF0F0_00FF, 32'h0FF0_FF0F, 32'h000F_0000);
    for (int i = 0; i < 12; i++) begin
      a = $urandom; b = $urandom;
      check_alu("logic_rand", EXE_RES_LOGIC, ops[i % 4], a, b, ref_result(EXE_RES_LOGIC, ops[i % 4], a, b));
    end
    check_alu("nop_sel", EXE_RES_NOP, EXE_OP_AND, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
    check_hilo("logic_hilo_kept", m_hi, m_lo);
  endtask

  task automatic test_shift();
    logic [7:0] ops[3] = '{EXE_OP_SLL, EXE_OP_SRL, EXE_OP_SRA};
    logic [31:0] a, b;
    check_alu("sll_fixed", EXE_RES_SHIFT, EXE_OP_SLL, 32'd4, 32'h8000_0010, 32'h0000_0100);
    check_alu("srl_fixed", EXE_RES_SHIFT, EXE_OP_SRL, 32'd4, 32'h8000_0010, 32'h0800_0001);
    check_alu("sra_fixed", EXE_RES_SHIFT, EXE_OP_SRA, 32'd4, 32'h8000_0010, 32'hF800_0001);
    for (int i = 0; i < 12; i++) begin
      a = $urandom; b = $urandom;
      check_alu("shift_rand", EXE_RES_SHIFT, ops[i % 3], a, b, ref_result(EXE_RES_SHIFT, ops[i % 3], a, b));
    end
  endtask

  // Launch one divide, count stall cycles, then check HI/LO in DONE and read back via MFHI/MFLO.
  task automatic test_div(input string name, input bit sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eq, er;
    int exp_stalls, stalls;
    if (b == 32'd0) begin
      eq = 32'hFFFF_FFFF; er = a; exp_stalls = 1;
    end else if (sgn) begin
      eq = $signed(a) / $signed(b); er = $signed(a) % $signed(b); exp_stalls = DivCycles + 1;
    end else begin
      eq = a / b; er = a % b; exp_stalls = DivCycles + 1;
    end
    @(negedge clk);
    drive(EXE_RES_NOP, sgn ? EXE_OP_DIV : EXE_OP_DIVU, a, b);
    wreg_i = 1'b1;
    stalls = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (i == 0) begin
        checks++;
        if (wreg_o !== 1'b0) begin
          errors++;
          $display("FAIL %s_wreg got %b want 0", name, wreg_o);
        end
      end
      if (stall_req_o !== 1'b1) break;
      stalls++;
      @(negedge clk);
    end
    checks++;
    if (stalls != exp_stalls) begin
      errors++;
      $display("FAIL %s_stalls got %0d want %0d", name, stalls, exp_stalls);
    end
    m_hi = er; m_lo = eq;
    check_hilo({name, "_hilo"}, er, eq);
    drive(EXE_RES_MOVE, EXE_OP_MFLO, 32'd0, 32'd0);
    #1;
    checks++;
    if (wdata_o !== eq) begin
      errors++;
      $display("FAIL %s_mflo got %h want %h", name, wdata_o, eq);
    end
    @(negedge clk);
    drive(EXE_RES_MOVE, EXE_OP_MFHI, 32'd0, 32'd0);
    #1;
    checks++;
    if (wdata_o !== er || stall_req_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_mfhi got %h stall %b want %h stall 0", name, wdata_o, stall_req_o, er);
    end
    drive(EXE_RES_NOP, EXE_OP_NOP, 32'd0, 32'd0);
  endtask

  task automatic test_div_random();
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if (b == 32'd0) b = 32'd3;
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd5;
      test_div("div_rand", i[0], a, b);
    end
  endtask

  task automatic test_abort(input bit use_rst, input int run_cycle);
    @(negedge clk);
    drive(EXE_RES_NOP, EXE_OP_DIV, 32'd1000, 32'd7);
    repeat (run_cycle + 1) @(negedge clk);
    if (use_rst) rst = 1'b1; else annul_i = 1'b1;
    #1;
    if (use_rst) begin m_hi = 32'd0; m_lo = 32'd0; end
    checks++;
    if (stall_req_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_stall got %b want 0 (rst=%b)", stall_req_o, use_rst);
    end
    check_hilo("abort_hilo", m_hi, m_lo);
    @(negedge clk);
    rst = 1'b0; annul_i = 1'b0;
    drive(EXE_RES_NOP, EXE_OP_NOP, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    #1;
    check_hilo("abort_hilo_later", m_hi, m_lo);
    // A fresh divide must take the full IDLE + RUN latency, proving the FSM restarted from IDLE.
    test_div("after_abort", 1'b0, 32'd12345, 32'd100);
  endtask

  task automatic test_annul_idle();
    @(negedge clk);
    annul_i = 1'b1;
    drive(EXE_RES_NOP, EXE_OP_DIV, 32'd5, 32'd0);
    #1;
    checks++;
    if (stall_req_o !== 1'b0) begin
      errors++;
      $display("FAIL annul_idle_stall got %b want 0", stall_req_o);
    end
    @(negedge clk);
    annul_i = 1'b0;
    drive(EXE_RES_NOP, EXE_OP_NOP, 32'd0, 32'd0);
    #1;
    check_hilo("annul_idle_hilo", m_hi, m_lo);
  endtask

  initial begin
    test_reset();
    test_logic();
    test_shift();
    test_div("div_neg7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
    test_div("divu_big", 1'b0, 32'hFFFF_FFFF, 32'h10);
    test_div("div_by_zero", 1'b1, 32'd5, 32'd0);
    test_div("divu_by_zero", 1'b0, 32'h8765_4321, 32'd0);
    test_div("div_neg_neg", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9);
    test_div_random();
    test_annul_idle();
    test_abort(1'b0, 10);
    test_abort(1'b1, 20);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
